// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller in front of the 32-bit ALU.
// It decodes one MIPS instruction per handshake and drives ALUControl, A and B.
// It holds those for one cycle, or for MUL_CYCLES cycles on a multiply.
// It then captures the ALU result and presents it on a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic [4:0]  Shamt,
    input  logic [15:0] Imm,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic [3:0]  ALUControl,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Result,
    output logic        ZeroOut,
    output logic        Illegal
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

    localparam logic [3:0] CntMul = 4'(MUL_CYCLES);

    state_t      state;
    logic [3:0]  cnt;

    logic [3:0]  dec_ctrl;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        dec_illegal;
    logic        dec_mul;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] shamt_zext;

    assign imm_sext   = {{16{Imm[15]}}, Imm};
    assign imm_zext   = {16'h0000, Imm};
    assign shamt_zext = {27'd0, Shamt};

    // Decode the live instruction fields; only used at the accept edge.
    always_comb begin
        dec_ctrl    = 4'b0010;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        case (Opcode)
            6'h00: begin
                dec_a = RsData;
                dec_b = RtData;
                case (Funct)
                    6'h24:        dec_ctrl = 4'b0000;
                    6'h25:        dec_ctrl = 4'b0001;
                    6'h20, 6'h21: dec_ctrl = 4'b0010;
                    6'h22, 6'h23: dec_ctrl = 4'b0011;
                    6'h2A:        dec_ctrl = 4'b0100;
                    6'h27:        dec_ctrl = 4'b0101;
                    6'h26:        dec_ctrl = 4'b1010;
                    6'h00: begin
                        dec_ctrl = 4'b1000;
                        dec_a    = RtData;
                        dec_b    = shamt_zext;
                    end
                    6'h02: begin
                        dec_ctrl = 4'b1001;
                        dec_a    = RtData;
                        dec_b    = shamt_zext;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h1C: begin
                if (Funct == 6'h02) begin
                    dec_ctrl = 4'b1111;
                    dec_a    = RsData;
                    dec_b    = RtData;
                    dec_mul  = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            6'h08, 6'h09: begin
                dec_ctrl = 4'b0010;
                dec_a    = RsData;
                dec_b    = imm_sext;
            end
            6'h0A: begin
                dec_ctrl = 4'b0100;
                dec_a    = RsData;
                dec_b    = imm_sext;
            end
            6'h0C: begin
                dec_ctrl = 4'b0000;
                dec_a    = RsData;
                dec_b    = imm_zext;
            end
            6'h0D: begin
                dec_ctrl = 4'b0001;
                dec_a    = RsData;
                dec_b    = imm_zext;
            end
            6'h0E: begin
                dec_ctrl = 4'b1010;
                dec_a    = RsData;
                dec_b    = imm_zext;
            end
            6'h04, 6'h05: begin
                dec_ctrl = 4'b0011;
                dec_a    = RsData;
                dec_b    = RtData;
            end
            6'h07: begin
                dec_ctrl = 4'b1101;
                dec_a    = RsData;
            end
            6'h06: begin
                dec_ctrl = 4'b1110;
                dec_a    = RsData;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal instructions issue a harmless 0 + 0.
        if (dec_illegal) begin
            dec_ctrl = 4'b0010;
            dec_a    = '0;
            dec_b    = '0;
            dec_mul  = 1'b0;
        end
    end

    // Issue FSM with registered handshake flags, operands and captured result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= StIdle;
            cnt        <= 4'd0;
            InReady    <= 1'b1;
            OutValid   <= 1'b0;
            ALUControl <= 4'b0000;
            A          <= '0;
            B          <= '0;
            Result     <= '0;
            ZeroOut    <= 1'b0;
            Illegal    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (InValid) begin
                        ALUControl <= dec_ctrl;
                        A          <= dec_a;
                        B          <= dec_b;
                        Illegal    <= dec_illegal;
                        cnt        <= dec_mul ? CntMul : 4'd1;
                        InReady    <= 1'b0;
                        state      <= StExec;
                    end
                end
                StExec: begin
                    if (cnt == 4'd1) begin
                        Result   <= ALUResult;
                        ZeroOut  <= Zero;
                        OutValid <= 1'b1;
                        state    <= StDone;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StDone: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                        state    <= StIdle;
                    end
                end
                default: begin
                    state    <= StIdle;
                    InReady  <= 1'b1;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
